// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin values,
// credit limit and the item price table.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StIssue,
    StWait
  } state_e;

  localparam int unsigned CreditW   = 6;
  localparam logic [5:0]  CoinVal1  = 6'd1;
  localparam logic [5:0]  CoinVal5  = 6'd5;
  localparam logic [5:0]  CoinVal10 = 6'd10;
  localparam logic [6:0]  CreditMax = 7'd63;

  function automatic logic [5:0] item_price(input logic [1:0] item);
    logic [5:0] price;
    unique case (item)
      2'd0:    price = 6'd3;
      2'd1:    price = 6'd12;
      2'd2:    price = 6'd25;
      default: price = 6'd40;
    endcase
    return price;
  endfunction

endpackage

// File: rtl/vend_coin_dec.sv
// Coin decoder: maps the 2-bit coin code to its credit value and flags the illegal code.
module vend_coin_dec
  import vend_pkg::*;
(
  input  logic [1:0]         coin_type_i,
  output logic [CreditW-1:0] value_o,
  output logic               legal_o
);

  always_comb begin
    value_o = '0;
    legal_o = 1'b1;
    case (coin_type_i)
      2'b00:   value_o = CoinVal1;
      2'b01:   value_o = CoinVal5;
      2'b10:   value_o = CoinVal10;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: collects coins into credit, handles selections and refunds,
// and hands the change value to a downstream change-maker. All outputs are registered.
module vend_ctrl
  import vend_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coin_valid,
  input  logic [1:0]         coin_type,
  input  logic               sel_valid,
  input  logic [1:0]         sel_item,
  input  logic               cancel,
  input  logic               change_done,
  output logic [CreditW-1:0] change_amt,
  output logic               change_valid,
  output logic               item_valid,
  output logic [1:0]         item_out,
  output logic               coin_reject,
  output logic               sel_fail,
  output logic               busy,
  output logic [CreditW-1:0] credit
);

  state_e               state_q, state_d;
  logic [CreditW-1:0]   credit_q, credit_d;
  logic [CreditW-1:0]   change_amt_q, change_amt_d;
  logic [1:0]           item_out_q, item_out_d;
  logic                 change_valid_q, change_valid_d;
  logic                 item_valid_q, item_valid_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 sel_fail_q, sel_fail_d;
  logic                 busy_q, busy_d;

  logic [CreditW-1:0]   coin_value;
  logic                 coin_legal;
  logic [CreditW:0]     coin_sum;
  logic                 coin_ok;
  logic [CreditW-1:0]   price;

  vend_coin_dec u_coin_dec (
    .coin_type_i (coin_type),
    .value_o     (coin_value),
    .legal_o     (coin_legal)
  );

  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok  = coin_legal && (coin_sum <= CreditMax);
  assign price    = item_price(sel_item);

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_amt_d   = change_amt_q;
    item_out_d     = item_out_q;
    change_valid_d = 1'b0;
    item_valid_d   = 1'b0;
    coin_reject_d  = 1'b0;
    sel_fail_d     = 1'b0;
    busy_d         = 1'b0;

    unique case (state_q)
      StIdle, StCollect: begin
        if (cancel) begin
          // A coin alongside a higher-priority event is always handed back.
          coin_reject_d = coin_valid;
          if (state_q == StCollect) begin
            change_amt_d   = credit_q;
            change_valid_d = 1'b1;
            busy_d         = 1'b1;
            state_d        = StIssue;
          end
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (state_q == StCollect && credit_q >= price) begin
            change_amt_d   = credit_q - price;
            item_out_d     = sel_item;
            change_valid_d = 1'b1;
            item_valid_d   = 1'b1;
            busy_d         = 1'b1;
            state_d        = StIssue;
          end else begin
            sel_fail_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[CreditW-1:0];
            state_d  = StCollect;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      StIssue: begin
        coin_reject_d = coin_valid;
        busy_d        = 1'b1;
        state_d       = StWait;
      end
      StWait: begin
        coin_reject_d = coin_valid;
        if (change_done) begin
          credit_d = '0;
          state_d  = StIdle;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      change_amt_q   <= '0;
      item_out_q     <= '0;
      change_valid_q <= 1'b0;
      item_valid_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_fail_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      item_out_q     <= item_out_d;
      change_valid_q <= change_valid_d;
      item_valid_q   <= item_valid_d;
      coin_reject_q  <= coin_reject_d;
      sel_fail_q     <= sel_fail_d;
      busy_q         <= busy_d;
    end
  end

  assign change_amt   = change_amt_q;
  assign change_valid = change_valid_q;
  assign item_valid   = item_valid_q;
  assign item_out     = item_out_q;
  assign coin_reject  = coin_reject_q;
  assign sel_fail     = sel_fail_q;
  assign busy         = busy_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios then random traffic, each cycle compared
// against a transaction-level model of credit, payout and pulses.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, sel_valid, cancel, change_done;
  logic [1:0] coin_type, sel_item;
  logic [5:0] change_amt, credit;
  logic       change_valid, item_valid, coin_reject, sel_fail, busy;
  logic [1:0] item_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a transaction is either in progress (paying) or not.
  int coin_val [4] = '{1, 5, 10, 0};
  int price_tbl[4] = '{3, 12, 25, 40};
  int m_credit;
  bit m_paying, m_first;
  int e_change_amt, e_item_out;
  bit e_cv, e_iv, e_rej, e_sf;

  vend_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .change_done  (change_done),
    .change_amt   (change_amt),
    .change_valid (change_valid),
    .item_valid   (item_valid),
    .item_out     (item_out),
    .coin_reject  (coin_reject),
    .sel_fail     (sel_fail),
    .busy         (busy),
    .credit       (credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_paying = 0; m_first = 0;
    e_change_amt = 0; e_item_out = 0;
    e_cv = 0; e_iv = 0; e_rej = 0; e_sf = 0;
  endtask

  // Apply this cycle's inputs to the model (called after the edge that sampled them).
  task automatic model_step();
    e_cv = 0; e_iv = 0; e_rej = 0; e_sf = 0;
    if (!m_paying) begin
      if (cancel) begin
        e_rej = coin_valid;
        if (m_credit > 0) begin
          e_change_amt = m_credit; e_cv = 1; m_paying = 1; m_first = 1;
        end
      end else if (sel_valid) begin
        e_rej = coin_valid;
        if (m_credit > 0 && m_credit >= price_tbl[sel_item]) begin
          e_change_amt = m_credit - price_tbl[sel_item];
          e_item_out = sel_item; e_cv = 1; e_iv = 1; m_paying = 1; m_first = 1;
        end else begin
          e_sf = 1;
        end
      end else if (coin_valid) begin
        if (coin_type == 2'b11 || m_credit + coin_val[coin_type] > 63) e_rej = 1;
        else m_credit += coin_val[coin_type];
      end
    end else if (m_first) begin
      e_rej = coin_valid; m_first = 0;
    end else begin
      e_rej = coin_valid;
      if (change_done) begin
        m_credit = 0; m_paying = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":credit"}, credit, m_credit);
    check({tag, ":change_amt"}, change_amt, e_change_amt);
    check({tag, ":item_out"}, item_out, e_item_out);
    check({tag, ":change_valid"}, change_valid, e_cv);
    check({tag, ":item_valid"}, item_valid, e_iv);
    check({tag, ":coin_reject"}, coin_reject, e_rej);
    check({tag, ":sel_fail"}, sel_fail, e_sf);
    check({tag, ":busy"}, busy, m_paying);
  endtask

  task automatic step(input string tag, input bit cv, input logic [1:0] ct, input bit sv,
                      input logic [1:0] si, input bit cn, input bit cd);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel_item = si;
    cancel = cn; change_done = cd;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 2'd0, 0, 2'd0, 0, 0);
  endtask

  task automatic coin(input string tag, input logic [1:0] ct);
    step(tag, 1, ct, 0, 2'd0, 0, 0);
  endtask

  task automatic done(input string tag);
    step(tag, 0, 2'd0, 0, 2'd0, 0, 1);
  endtask

  initial begin
    rst_n = 0; coin_valid = 0; coin_type = 0; sel_valid = 0; sel_item = 0;
    cancel = 0; change_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1;

    // Purchase item1 with 10+10+5: change 13.
    coin("buy_c10a", 2'b10);
    coin("buy_c10b", 2'b10);
    coin("buy_c5", 2'b01);
    check("buy_credit25", credit, 25);
    step("buy_sel1", 0, 2'd0, 1, 2'd1, 0, 0);
    check("buy_change13", change_amt, 13);
    check("buy_item_valid", item_valid, 1);
    idle("buy_issue_end");
    check("buy_cv_pulse_once", change_valid, 0);
    idle("buy_wait");
    step("buy_done_early_sel", 0, 2'd0, 1, 2'd0, 1, 1);
    check("buy_credit0", credit, 0);

    // Insufficient credit for item2, then refund.
    coin("low_c5", 2'b01);
    step("low_sel2", 0, 2'd0, 1, 2'd2, 0, 0);
    check("low_sel_fail", sel_fail, 1);
    step("low_cancel", 0, 2'd0, 0, 2'd0, 1, 0);
    check("low_refund5", change_amt, 5);
    idle("low_issue");
    done("low_done");

    // 10+1 then cancel.
    coin("can_c10", 2'b10);
    coin("can_c1", 2'b00);
    step("can_cancel", 0, 2'd0, 0, 2'd0, 1, 0);
    check("can_change11", change_amt, 11);
    check("can_no_item", item_valid, 0);
    idle("can_issue");
    done("can_done");

    // Credit ceiling and illegal coin.
    for (int i = 0; i < 6; i++) coin("cap_c10", 2'b10);
    coin("cap_c10_7th", 2'b10);
    check("cap_credit60", credit, 60);
    check("cap_reject", coin_reject, 1);
    coin("cap_c1", 2'b00);
    coin("cap_illegal", 2'b11);
    check("cap_illegal_reject", coin_reject, 1);
    step("cap_cancel", 0, 2'd0, 0, 2'd0, 1, 0);
    idle("cap_issue");
    done("cap_done");

    // Coins during payout, coin together with a selection.
    coin("busy_c10", 2'b10);
    step("busy_sel0", 0, 2'd0, 1, 2'd0, 0, 0);
    coin("busy_coin_issue", 2'b10);
    coin("busy_coin_wait", 2'b10);
    check("busy_wait_reject", coin_reject, 1);
    done("busy_done");
    coin("mix_c10", 2'b10);
    step("mix_c5_sel0", 1, 2'b01, 1, 2'd0, 0, 0);
    check("mix_change7", change_amt, 7);
    idle("mix_issue");
    idle("mix_wait");

    // Reset in WAIT.
    rst_n = 0;
    #1;
    model_reset();
    check_all("rst_wait");
    @(posedge clk);
    #1;
    rst_n = 1;
    check_all("rst_after");
    coin("rst_c1", 2'b00);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom % 3) == 0, 2'($urandom), ($urandom % 6) == 0, 2'($urandom),
           ($urandom % 15) == 0, ($urandom % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
